// File: rtl/u_rec_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package u_rec_pkg;

   typedef enum logic [2:0] {
      R_ARM    = 3'd0,
      R_IDLE   = 3'd1,
      R_START  = 3'd2,
      R_DATA   = 3'd3,
      R_PARITY = 3'd4,
      R_STOP   = 3'd5
   } rec_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic bit params_ok(
      input int db,
      input int os,
      input int pe,
      input int po,
      input int sb,
      input int ss
   );
      return (db >= 5) && (db <= 9) &&
             (os >= 8) && (os <= 32) && (os % 2 == 0) &&
             (pe == 0 || pe == 1) &&
             (po == 0 || po == 1) &&
             (sb == 1 || sb == 2) &&
             (ss >= 2) && (ss <= 3);
   endfunction

endpackage

// File: rtl/u_rec_sync.sv
// Input synchroniser, idle-high reset, plus a flush-done indication.
module u_rec_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o,
   output logic vld_o
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] vld_q;

   // vld_o rises once the reset value has been flushed out of the chain
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= '1;
         vld_q  <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         vld_q  <= {vld_q[STAGES-2:0], 1'b1};
      end
   end

   assign q_o   = sync_q[STAGES-1];
   assign vld_o = vld_q[STAGES-1];

endmodule

// File: rtl/u_rec_cfg.sv
// Parametrised UART receiver with held-word handshake and error flags.
module u_rec_cfg
   import u_rec_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int PARITY_EN   = 0,
   parameter int PARITY_ODD  = 0,
   parameter int STOP_BITS   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_l,
   input  logic                 bit_tickH,
   input  logic                 uart_dataH,
   input  logic                 rec_ackH,
   output logic [DATA_BITS-1:0] rec_dataH,
   output logic                 rec_readyH,
   output logic                 rec_parity_errH,
   output logic                 rec_frame_errH,
   output logic                 rec_breakH,
   output logic                 rec_overrunH
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 3);
   localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DLST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] SLST = BW'(STOP_BITS - 1);
   localparam logic PAR_BIT = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

   if (!params_ok(DATA_BITS, OVERSAMPLE, PARITY_EN,
                  PARITY_ODD, STOP_BITS, SYNC_STAGES)) begin : g_bad_cfg
      $error("u_rec_cfg: illegal parameter set");
   end

   logic rx;
   logic rx_vld;

   u_rec_sync #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i (sys_clk),
      .rst_ni(sys_rst_l),
      .d_i   (uart_dataH),
      .q_o   (rx),
      .vld_o (rx_vld)
   );

   rec_state_e           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shf_q, shf_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 low_q, low_d;

   logic                 dlv;
   logic                 dlv_fe;
   logic                 dlv_bk;
   logic                 load;

   logic [DATA_BITS-1:0] data_q;
   logic                 rdy_q, pe_q, fe_q, bk_q, ov_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shf_d   = shf_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      low_d   = low_q;
      dlv     = 1'b0;
      dlv_fe  = ferr_q | ~rx;
      dlv_bk  = low_q & ~rx;
      if (bit_tickH) begin
         cnt_d = cnt_q + CW'(1);
         unique case (state_q)
            R_ARM: begin
               cnt_d = '0;
               if (rx && rx_vld) state_d = R_IDLE;
            end
            R_IDLE: begin
               cnt_d = '0;
               if (!rx) state_d = R_START;
            end
            R_START: begin
               if (cnt_q == MID) begin
                  cnt_d   = '0;
                  bit_d   = '0;
                  perr_d  = 1'b0;
                  ferr_d  = 1'b0;
                  low_d   = 1'b1;
                  state_d = rx ? R_IDLE : R_DATA;
               end
            end
            R_DATA: begin
               if (cnt_q == LAST) begin
                  cnt_d = '0;
                  shf_d = {rx, shf_q[DATA_BITS-1:1]};
                  low_d = low_q & ~rx;
                  bit_d = bit_q + BW'(1);
                  if (bit_q == DLST) begin
                     bit_d   = '0;
                     state_d = (PARITY_EN != 0) ? R_PARITY : R_STOP;
                  end
               end
            end
            R_PARITY: begin
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  perr_d  = (^shf_q) ^ rx ^ PAR_BIT;
                  low_d   = low_q & ~rx;
                  state_d = R_STOP;
               end
            end
            R_STOP: begin
               if (cnt_q == LAST) begin
                  cnt_d  = '0;
                  ferr_d = dlv_fe;
                  low_d  = dlv_bk;
                  bit_d  = bit_q + BW'(1);
                  // deliver mid last stop bit so back-to-back starts are seen
                  if (bit_q == SLST) begin
                     dlv     = 1'b1;
                     state_d = dlv_bk ? R_ARM : R_IDLE;
                  end
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = R_ARM;
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_l) begin
         state_q <= R_ARM;
         cnt_q   <= '0;
         bit_q   <= '0;
         shf_q   <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         low_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shf_q   <= shf_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         low_q   <= low_d;
      end
   end

   assign load = dlv && (!rdy_q || rec_ackH);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_l) begin
         data_q <= '0;
         rdy_q  <= 1'b0;
         pe_q   <= 1'b0;
         fe_q   <= 1'b0;
         bk_q   <= 1'b0;
         ov_q   <= 1'b0;
      end else begin
         if (load) begin
            data_q <= shf_q;
            rdy_q  <= 1'b1;
            pe_q   <= perr_q;
            fe_q   <= dlv_fe;
            bk_q   <= dlv_bk;
         end else if (rec_ackH && rdy_q) begin
            rdy_q <= 1'b0;
            pe_q  <= 1'b0;
            fe_q  <= 1'b0;
            bk_q  <= 1'b0;
         end
         if (dlv && rdy_q && !rec_ackH) ov_q <= 1'b1;
         else if (rec_ackH && rdy_q) ov_q <= 1'b0;
      end
   end

   assign rec_dataH       = data_q;
   assign rec_readyH      = rdy_q;
   assign rec_parity_errH = pe_q;
   assign rec_frame_errH  = fe_q;
   assign rec_breakH      = bk_q;
   assign rec_overrunH    = ov_q;

endmodule

// File: tb/tb_u_rec_cfg.sv
// Scoreboard bench: dut0 8N1, dut1 8E1, dut2 8N2, all at 16x oversample.
module tb_u_rec_cfg;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       bk;
      int         lat;
      int         tf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_l = 1'b0;
   logic       line [3];
   logic       ack [3];
   logic [7:0] dat [3];
   logic       rdy [3];
   logic       pe [3];
   logic       fe [3];
   logic       bk [3];
   logic       ov [3];

   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   u_rec_cfg #(
      .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0),
      .PARITY_ODD(0), .STOP_BITS(1), .SYNC_STAGES(2)
   ) dut0 (
      .sys_clk(clk), .sys_rst_l(rst_l), .bit_tickH(1'b1),
      .uart_dataH(line[0]), .rec_ackH(ack[0]),
      .rec_dataH(dat[0]), .rec_readyH(rdy[0]),
      .rec_parity_errH(pe[0]), .rec_frame_errH(fe[0]),
      .rec_breakH(bk[0]), .rec_overrunH(ov[0])
   );

   u_rec_cfg #(
      .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1),
      .PARITY_ODD(0), .STOP_BITS(1), .SYNC_STAGES(2)
   ) dut1 (
      .sys_clk(clk), .sys_rst_l(rst_l), .bit_tickH(1'b1),
      .uart_dataH(line[1]), .rec_ackH(ack[1]),
      .rec_dataH(dat[1]), .rec_readyH(rdy[1]),
      .rec_parity_errH(pe[1]), .rec_frame_errH(fe[1]),
      .rec_breakH(bk[1]), .rec_overrunH(ov[1])
   );

   u_rec_cfg #(
      .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0),
      .PARITY_ODD(0), .STOP_BITS(2), .SYNC_STAGES(2)
   ) dut2 (
      .sys_clk(clk), .sys_rst_l(rst_l), .bit_tickH(1'b1),
      .uart_dataH(line[2]), .rec_ackH(ack[2]),
      .rec_dataH(dat[2]), .rec_readyH(rdy[2]),
      .rec_parity_errH(pe[2]), .rec_frame_errH(fe[2]),
      .rec_breakH(bk[2]), .rec_overrunH(ov[2])
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic int qsize(input int idx);
      case (idx)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic exp_t qpop(input int idx);
      exp_t e;
      case (idx)
         0: e = q0.pop_front();
         1: e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
      return e;
   endfunction

   task automatic expect_word(input int idx, input logic [7:0] d,
                              input logic p, input logic f,
                              input logic b, input int lat);
      exp_t e;
      e.d = d; e.pe = p; e.fe = f; e.bk = b;
      e.lat = lat; e.tf = cyc;
      case (idx)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic drive(input int idx, input logic v);
      line[idx] = v;
      repeat (16) @(negedge clk);
   endtask

   task automatic send_frame(input int idx, input logic [7:0] d,
                             input bit par_en, input logic p,
                             input int nstop, input logic [1:0] stops);
      drive(idx, 1'b0);
      for (int i = 0; i < 8; i++) drive(idx, d[i]);
      if (par_en) drive(idx, p);
      for (int i = 0; i < nstop; i++) drive(idx, stops[i]);
   endtask

   task automatic pulse_ack(input int idx);
      ack[idx] = 1'b1;
      @(negedge clk);
      ack[idx] = 1'b0;
   endtask

   task automatic wait_ack(input int idx);
      int n = 0;
      while (!rdy[idx] && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!rdy[idx]) begin
         fails++;
         $display("FAIL dut%0d_ready_timeout actual=0 required=1", idx);
      end else begin
         pulse_ack(idx);
      end
   endtask

   task automatic monitor(input int idx);
      bit   seen = 1'b0;
      logic a, r;
      exp_t e;
      forever begin
         @(posedge clk);
         a = ack[idx];
         r = rdy[idx];
         #1;
         if (a && r) seen = 1'b0;
         if (!rdy[idx]) begin
            seen = 1'b0;
         end else if (!seen) begin
            seen = 1'b1;
            if (qsize(idx) == 0) begin
               checks++;
               fails++;
               $display("FAIL dut%0d_unexpected_word actual=%0h required=none",
                        idx, dat[idx]);
            end else begin
               e = qpop(idx);
               chk($sformatf("dut%0d_data", idx), 32'(dat[idx]), 32'(e.d));
               chk($sformatf("dut%0d_parity", idx), 32'(pe[idx]), 32'(e.pe));
               chk($sformatf("dut%0d_frame", idx), 32'(fe[idx]), 32'(e.fe));
               chk($sformatf("dut%0d_break", idx), 32'(bk[idx]), 32'(e.bk));
               if (e.lat != 0)
                  chk($sformatf("dut%0d_latency", idx), 32'(cyc - e.tf),
                      32'(e.lat));
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         line[i] = 1'b1;
         ack[i]  = 1'b0;
      end
      fork
         monitor(0);
         monitor(1);
         monitor(2);
      join_none
      repeat (5) @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'd0);
         chk($sformatf("rst_overrun%0d", i), 32'(ov[i]), 32'd0);
         chk($sformatf("rst_data%0d", i), 32'(dat[i]), 32'd0);
      end
      repeat (20) @(negedge clk);

      expect_word(0, 8'h55, 1'b0, 1'b0, 1'b0, 155);
      send_frame(0, 8'h55, 1'b0, 1'b0, 1, 2'b11);
      wait_ack(0);
      repeat (5) @(negedge clk);

      expect_word(0, 8'h11, 1'b0, 1'b0, 1'b0, 155);
      send_frame(0, 8'h11, 1'b0, 1'b0, 1, 2'b11);
      send_frame(0, 8'h22, 1'b0, 1'b0, 1, 2'b11);
      chk("ovr_ready", 32'(rdy[0]), 32'd1);
      chk("ovr_data_held", 32'(dat[0]), 32'h11);
      chk("ovr_flag_set", 32'(ov[0]), 32'd1);
      pulse_ack(0);
      chk("ovr_ack_ready", 32'(rdy[0]), 32'd0);
      chk("ovr_ack_clear", 32'(ov[0]), 32'd0);
      repeat (5) @(negedge clk);

      expect_word(0, 8'h33, 1'b0, 1'b0, 1'b0, 155);
      send_frame(0, 8'h33, 1'b0, 1'b0, 1, 2'b11);
      chk("w33_overrun", 32'(ov[0]), 32'd0);

      expect_word(0, 8'h44, 1'b0, 1'b0, 1'b0, 155);
      fork
         send_frame(0, 8'h44, 1'b0, 1'b0, 1, 2'b11);
         begin
            repeat (154) @(negedge clk);
            pulse_ack(0);
         end
      join
      chk("same_ack_ready", 32'(rdy[0]), 32'd1);
      chk("same_ack_data", 32'(dat[0]), 32'h44);
      chk("same_ack_overrun", 32'(ov[0]), 32'd0);
      pulse_ack(0);

      line[0] = 1'b0;
      repeat (3) @(negedge clk);
      line[0] = 1'b1;
      repeat (200) @(negedge clk);
      chk("glitch_no_ready", 32'(rdy[0]), 32'd0);

      line[0] = 1'b0;
      repeat (60) @(negedge clk);
      rst_l = 1'b0;
      repeat (3) @(negedge clk);
      rst_l = 1'b1;
      repeat (300) @(negedge clk);
      line[0] = 1'b1;
      repeat (50) @(negedge clk);
      chk("rst_mid_ready", 32'(rdy[0]), 32'd0);
      chk("rst_mid_overrun", 32'(ov[0]), 32'd0);
      expect_word(0, 8'h7E, 1'b0, 1'b0, 1'b0, 155);
      send_frame(0, 8'h7E, 1'b0, 1'b0, 1, 2'b11);
      wait_ack(0);

      expect_word(1, 8'hA3, 1'b1, 1'b0, 1'b0, 171);
      send_frame(1, 8'hA3, 1'b1, 1'b1, 1, 2'b11);
      wait_ack(1);
      repeat (5) @(negedge clk);
      expect_word(1, 8'hA3, 1'b0, 1'b0, 1'b0, 171);
      send_frame(1, 8'hA3, 1'b1, 1'b0, 1, 2'b11);
      wait_ack(1);

      expect_word(2, 8'h0F, 1'b0, 1'b1, 1'b0, 171);
      send_frame(2, 8'h0F, 1'b0, 1'b0, 2, 2'b01);
      line[2] = 1'b1;
      wait_ack(2);
      repeat (40) @(negedge clk);
      expect_word(2, 8'h00, 1'b0, 1'b1, 1'b1, 171);
      line[2] = 1'b0;
      repeat (352) @(negedge clk);
      wait_ack(2);
      line[2] = 1'b1;
      repeat (300) @(negedge clk);
      chk("break_single_word", 32'(rdy[2]), 32'd0);

      repeat (10) @(negedge clk);
      for (int i = 0; i < 3; i++)
         chk($sformatf("dut%0d_pending", i), 32'(qsize(i)), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/u_rec_cfg.md
Name: u_rec_cfg

Overview:
Parametrised UART receiver, the next-generation replacement for the fixed 8N1 receiver in the serial front end.
- Configurable data width, oversample ratio, optional parity and 1 or 2 stop bits; fractional baud rates via an external oversample tick.
- Holds each received word behind a ready/ack handshake.
- Reports parity, framing, break and overrun conditions alongside the word.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
OVERSAMPLE, 16, ticks per bit, even, legal 8..32
PARITY_EN, 0, 1 = parity bit follows the data
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits checked, 1 or 2
SYNC_STAGES, 2, input synchroniser depth, legal 2..3

Ports:
sys_clk  in  1  system clock
sys_rst_l  in  1  reset; synchronous to sys_clk, active-low
bit_tickH  in  1  oversample enable; tie high when sys_clk = OVERSAMPLE x baud
uart_dataH  in  1  asynchronous serial line, idle high
rec_ackH  in  1  consumer accepts the held word
rec_dataH  out  DATA_BITS  received word, stable while rec_readyH is high
rec_readyH  out  1  word held and unconsumed
rec_parity_errH  out  1  parity mismatch on the held word
rec_frame_errH  out  1  a stop bit sampled low on the held word
rec_breakH  out  1  break detected: data, parity and stop all sampled low
rec_overrunH  out  1  sticky flag: a frame was dropped because the holding register was full

Behaviour:
- Reset: on a sys_clk edge with sys_rst_l low, all outputs go to 0, synchroniser stages go to 1, FSM goes to R_ARM, counters clear. Reset mid-frame aborts the frame; no word and no flags are produced.
- Timing: the synchroniser delays the line by SYNC_STAGES cycles. Counters and the FSM advance only when bit_tickH=1; the holding register and handshake logic run every cycle.
- R_ARM: wait for the synchronised line to be high on one tick, then go to R_IDLE. This rule also applies after reset and after a break, so a line that is already low is never taken as a start bit.
- R_IDLE: synchronised line low -> R_START; clear the tick counter.
- R_START: at tick count OVERSAMPLE/2-1 (mid start bit), sample the line:
  - line high -> glitch; return to R_IDLE with no output;
  - line low -> R_DATA; clear counters.
- R_DATA: sample one bit every OVERSAMPLE ticks, shifting into the MSB of a DATA_BITS register. After DATA_BITS samples go to R_PARITY if PARITY_EN, else R_STOP.
- R_PARITY: sample one bit; parity_err = XOR(data, sampled bit) != PARITY_ODD.
- R_STOP: sample STOP_BITS bits, one per OVERSAMPLE ticks; any low stop bit sets frame_err. At the mid-point of the last stop bit, deliver the word, then:
  - break condition -> R_ARM;
  - otherwise -> R_IDLE. No wait for the end of the stop bit, so back-to-back frames are accepted.
- Latency (bit_tickH tied high): rec_readyH rises SYNC_STAGES + OVERSAMPLE/2 + (DATA_BITS+PARITY_EN+STOP_BITS)*OVERSAMPLE + 1 cycles after uart_dataH falls. For 8N1 at OVERSAMPLE=16 this is 155.
- Delivery: if rec_readyH is 0, or rec_ackH is 1 in the same cycle, load rec_dataH and the three per-word error flags together and set rec_readyH=1 on the next edge.
  - Simultaneous ack and delivery: the new word replaces the old one and rec_readyH stays high; not an overrun.
- Overrun: delivery while rec_readyH=1 with no ack:
  - the new word is discarded and the held word and flags are unchanged;
  - rec_overrunH is set and stays set until the next accepted ack.
- Ack: rec_ackH with rec_readyH=1 and no delivery -> rec_readyH and the per-word flags clear next edge. rec_ackH with rec_readyH=0 is ignored.
- Flag validity: per-word flags are only valid while rec_readyH=1.
- Width: tick counter is $clog2(OVERSAMPLE) bits, bit counter $clog2(DATA_BITS+3) bits; no wrap is permitted within a frame.
- Illegal state -> R_ARM on the next tick.

Decomposition:
- Package u_rec_pkg:
  - FSM state enum (R_ARM, R_IDLE, R_START, R_DATA, R_PARITY, R_STOP);
  - parity mode constants;
  - a parameter-legality check function used by an elaboration-time assertion.
- One sub-module, u_rec_sync: SYNC_STAGES-deep synchroniser, resetting to 1.

Test Plan:
- 8N1, OVERSAMPLE=16, tick high; send 0x55 -> rec_dataH=0x55, rec_readyH rises at cycle 155 after line fall, all flags 0.
- PARITY_EN=1, PARITY_ODD=0; send 0xA3 with parity bit 1 (wrong) -> rec_dataH=0xA3, rec_parity_errH=1; repeat with parity 0 -> flag 0.
- 8N2; send 0x0F with second stop bit low -> rec_frame_errH=1, rec_breakH=0. Then hold the line low for 2 frames -> one word 0x00 with rec_breakH=1; no second word until the line returns high.
- Send 0x11 then 0x22 back-to-back without ack -> rec_dataH stays 0x11, rec_overrunH=1. Ack -> readyH clears and overrunH clears; a following 0x33 is delivered cleanly.
- Ack in the same cycle as delivery of 0x44 -> rec_readyH stays high, rec_dataH=0x44, rec_overrunH=0. A 3-tick low glitch on the idle line -> no rec_readyH.
- Assert sys_rst_l low mid-data with the line held low, release while still low -> no word delivered. After the line goes high, a following 0x7E is received correctly.
